// File: rtl/drum_mac_acc.sv
// Accumulates a vector of unsigned DRUM products into a saturating ACC_W-bit sum.
// The result is presented through a valid/ready output handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; sampling len clears acc/ovf and loads cnt
// ACCUM | prod_ready=1; each transfer adds prod and decrements cnt
// HOLD  | out_valid=1; result held until out_ready
module drum_mac_acc #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             prod_valid,
  input  logic [31:0]      prod,
  output logic             prod_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [LEN_W-1:0] cnt;
  logic             xfer;
  logic             load;
  logic [ACC_W:0]   sum;

  assign load = (state == IDLE) && start;
  assign xfer = (state == ACCUM) && prod_valid;
  assign sum  = {1'b0, acc} + {{(ACC_W + 1 - 32){1'b0}}, prod};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (prod_valid && (cnt == LEN_W'(1))) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Once ovf is set the sum stays pinned at all ones for the rest of the vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= len;
    end else if (xfer) begin
      cnt <= cnt - LEN_W'(1);
      if (sum[ACC_W] || ovf) begin
        acc <= '1;
        ovf <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end

  assign prod_ready = (state == ACCUM);
  assign out_valid  = (state == HOLD);
  assign busy       = (state != IDLE);
  assign out_acc    = acc;
  assign out_ovf    = ovf;

endmodule

// File: tb/tb_drum_mac_acc.sv
// Scoreboard bench for drum_mac_acc: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them on every output handshake.
module tb_drum_mac_acc;
  localparam int ACC_W = 33;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             prod_valid = 1'b0;
  logic [31:0]      prod = '0;
  logic             prod_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             busy;

  int tests = 0;
  int fails = 0;
  int xfer_cnt = 0;

  logic [ACC_W:0] exp_q[$];
  logic [31:0]    pv[8];
  bit             pat[8];
  int             pat_len = 1;

  drum_mac_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string name);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && prod_valid && prod_ready) xfer_cnt++;
  end

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    logic [ACC_W:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got result 0x%0h with nothing expected", out_acc);
      end else begin
        e = exp_q.pop_front();
        chk(64'(out_acc), 64'(e[ACC_W-1:0]), "sb_acc");
        chk(64'(out_ovf), 64'(e[ACC_W]), "sb_ovf");
      end
    end
  end

  task automatic do_start(input int n, input bit push, input logic [ACC_W-1:0] e_acc,
                          input bit e_ovf);
    @(posedge clk); #1;
    start = 1'b1;
    len   = LEN_W'(n);
    if (push) exp_q.push_back({e_ovf, e_acc});
    @(posedge clk); #1;
    start = 1'b0;
    len   = LEN_W'(8'hA5);
  endtask

  // Offers products pv[0..stop-1] following the valid pattern; returns at
  // posedge+1 after the last accepted transfer.
  task automatic feed(input int stop);
    int idx = 0;
    int cyc = 0;
    while (idx < stop && cyc < 200) begin
      prod_valid = pat[cyc % pat_len];
      prod       = pv[idx];
      @(negedge clk);
      chk(64'(prod_ready), 64'd1, "prod_ready_accum");
      if (prod_valid && prod_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    prod_valid = 1'b0;
    if (idx < stop) begin
      tests++;
      fails++;
      $display("FAIL feed_timeout: accepted %0d, required %0d", idx, stop);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    @(negedge clk);
    chk(64'(prod_ready), 64'd0, {tag, "_prod_ready"});
    chk(64'(out_valid), 64'd0, {tag, "_out_valid"});
    chk(64'(busy), 64'd0, {tag, "_busy"});
    chk(64'(out_acc), 64'd0, {tag, "_out_acc"});
    chk(64'(out_ovf), 64'd0, {tag, "_out_ovf"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    pat[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle_zero("reset");

    // Three back-to-back products.
    pv[0] = 100; pv[1] = 200; pv[2] = 300; pat_len = 1; pat[0] = 1'b1;
    x0 = xfer_cnt;
    do_start(3, 1'b1, 33'd600, 1'b0);
    feed(3);
    chk(64'(out_valid), 64'd1, "v1_latency");
    @(posedge clk); #1;
    chk(64'(out_valid), 64'd0, "v1_one_cycle");
    chk(64'(xfer_cnt - x0), 64'd3, "v1_xfers");

    // Gapped upstream 1-0-0-1-1-0-1.
    pv[0] = 10; pv[1] = 20; pv[2] = 30; pv[3] = 40;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; pat_len = 7;
    x0 = xfer_cnt;
    do_start(4, 1'b1, 33'd100, 1'b0);
    feed(4);
    chk(64'(out_valid), 64'd1, "v2_latency");
    @(posedge clk); #1;
    chk(64'(xfer_cnt - x0), 64'd4, "v2_xfers");
    pat_len = 1; pat[0] = 1'b1;

    // Saturation at ACC_W=33, then ovf cleared by the next start.
    pv[0] = 32'hFFFF_FFFF; pv[1] = 32'hFFFF_FFFF; pv[2] = 32'hFFFF_FFFF;
    do_start(3, 1'b1, 33'h1_FFFF_FFFF, 1'b1);
    feed(3);
    @(posedge clk); #1;
    pv[0] = 5;
    do_start(1, 1'b1, 33'd5, 1'b0);
    feed(1);
    @(posedge clk); #1;

    // Zero-length vector with upstream offering data.
    x0 = xfer_cnt;
    prod_valid = 1'b1; prod = 32'd77;
    do_start(0, 1'b1, 33'd0, 1'b0);
    chk(64'(out_valid), 64'd1, "len0_hold");
    @(posedge clk); #1;
    prod_valid = 1'b0;
    chk(64'(xfer_cnt - x0), 64'd0, "len0_no_xfer");

    // HOLD with back-pressure while start pulses and prod_valid is high.
    out_ready = 1'b0;
    pv[0] = 11; pv[1] = 22;
    do_start(2, 1'b1, 33'd33, 1'b0);
    feed(2);
    x0 = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0); len = 8'd3; prod_valid = 1'b1; prod = 32'd999;
      @(negedge clk);
      chk(64'(out_valid), 64'd1, "hold_valid");
      chk(64'(out_acc), 64'd33, "hold_acc_stable");
      chk(64'(prod_ready), 64'd0, "hold_no_ready");
      @(posedge clk); #1;
    end
    start = 1'b0; prod_valid = 1'b0;
    chk(64'(xfer_cnt - x0), 64'd0, "hold_no_xfer");
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk(64'(busy), 64'd0, "hold_to_idle");
    chk(64'(out_acc), 64'd33, "hold_start_ignored");

    // Reset after 2 of 5 products, asserted together with start and prod_valid.
    pv[0] = 1; pv[1] = 2; pv[2] = 3; pv[3] = 4; pv[4] = 5;
    do_start(5, 1'b0, '0, 1'b0);
    feed(2);
    rst = 1'b1; start = 1'b1; len = 8'd2; prod_valid = 1'b1; prod = 32'd50;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; prod_valid = 1'b0;
    chk_idle_zero("rst_accum");
    pv[0] = 7;
    do_start(1, 1'b1, 33'd7, 1'b0);
    feed(1);
    @(posedge clk); #1;

    // Reset while a result is pending in HOLD.
    out_ready = 1'b0;
    pv[0] = 9;
    do_start(1, 1'b0, '0, 1'b0);
    feed(1);
    chk(64'(out_valid), 64'd1, "rst_hold_pending");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk_idle_zero("rst_hold");

    repeat (3) @(posedge clk);
    #1;
    chk(64'(exp_q.size()), 64'd0, "sb_drained");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
